// File: rtl/seq_divider_if.sv
// Start/done handshake bundle between the execute stage and the sequential divider.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, fed by a
// WIDTH+1-bit ripple-borrow subtract chain.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ripple chain of single-bit full subtractors; returns {final_borrow, diff[WIDTH-1:0]}.
    // The top difference bit is never needed: a kept result is always below the divisor.
    function automatic logic [WIDTH:0] sub_chain(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        logic             br;
        logic [WIDTH-1:0] d;
        br = 1'b0;
        d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            d[i] = a[i] ^ b[i] ^ br;
            br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        br = (~a[WIDTH] & b[WIDTH]) | (~(a[WIDTH] ^ b[WIDTH]) & br);
        return {br, d};
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic [WIDTH:0]   trial_s;
    logic [WIDTH:0]   sub_s;
    logic             borrow_s;
    logic [WIDTH-1:0] p_next_s;
    logic [WIDTH-1:0] dvd_next_s;

    // One restoring step: trial subtract, then keep or restore the partial remainder.
    always_comb begin
        trial_s    = {p_r, dvd_r[WIDTH-1]};
        sub_s      = sub_chain(trial_s, {1'b0, dsr_r});
        borrow_s   = sub_s[WIDTH];
        if (borrow_s) begin
            p_next_s = trial_s[WIDTH-1:0];
        end else begin
            p_next_s = sub_s[WIDTH-1:0];
        end
        // Quotient bits fill the dividend register from the bottom as it shifts out.
        dvd_next_s = {dvd_r[WIDTH-2:0], ~borrow_s};
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            p_r         <= '0;
            dvd_r       <= '0;
            dsr_r       <= '0;
            cnt_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        if (bus.divisor != {WIDTH{1'b0}}) begin
                            p_r     <= '0;
                            dvd_r   <= bus.dividend;
                            dsr_r   <= bus.divisor;
                            cnt_r   <= CNT_W'(WIDTH);
                            dbz_r   <= 1'b0;
                            busy_r  <= 1'b1;
                            state_r <= RUN;
                        end else begin
                            quotient_r  <= {WIDTH{1'b1}};
                            remainder_r <= bus.dividend;
                            dbz_r       <= 1'b1;
                            done_r      <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= DONE;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    p_r   <= p_next_s;
                    dvd_r <= dvd_next_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        quotient_r  <= dvd_next_s;
                        remainder_r <= p_next_s;
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= DONE;
                    end else begin
                        done_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed vectors push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", bus.quotient, e.q);
                chk("remainder", bus.remainder, e.r);
                chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
                chk("busy_with_done", {31'd0, bus.busy}, 32'd0);
            end
        end
    end

    // Issue one operation at the current negedge and wait (bounded) for its done pulse.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic ed, input int glitch);
        exp_t e;
        int   lat;
        lat   = 0;
        e.q   = eq;
        e.r   = er;
        e.dbz = ed;
        sb.push_back(e);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        for (int i = 1; i <= 100 && lat == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.start    = 1'b0;
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
                chk("busy_after_accept", {31'd0, bus.busy}, (b != 32'd0) ? 32'd1 : 32'd0);
            end
            if (glitch > 0 && i == glitch) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd9;
                bus.divisor  = 32'd2;
            end else if (glitch > 0 && i == glitch + 1) begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) lat = i;
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in 100 cycles expected done");
        end else begin
            chk("latency", lat, (b == 32'd0) ? 32'd1 : 32'd33);
        end
    endtask

    initial begin
        int saw_done;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;
        @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_quotient", bus.quotient, 32'd0);
        chk("rst_remainder", bus.remainder, 32'd0);
        chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
        repeat (2) @(negedge clk);
        run_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
        run_div(32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 0);
        repeat (3) @(negedge clk);
        run_div(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
        chk("dbz_held", {31'd0, bus.div_by_zero}, 32'd1);
        run_div(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 11);
        @(negedge clk);
        chk("held_after_idle_q", bus.quotient, 32'd0);
        chk("held_after_idle_r", bus.remainder, 32'd3);
        // Second start is presented in the DONE cycle of the first: back-to-back.
        run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
        run_div(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 0);
        repeat (2) @(negedge clk);

        // Abandon an operation with an asynchronous reset mid-RUN.
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        chk("busy_before_rst", {31'd0, bus.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("async_rst_done", {31'd0, bus.done}, 32'd0);
        chk("async_rst_quotient", bus.quotient, 32'd0);
        chk("async_rst_remainder", bus.remainder, 32'd0);
        chk("async_rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1;
        end
        chk("no_done_after_rst", saw_done, 32'd0);

        run_div(32'd8, 32'd3, 32'd2, 32'd2, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("final_quotient_held", bus.quotient, 32'd2);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
